// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, state encodings and width helpers for the debounce bank
package debounce_pkg;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CLOCKS = 1500000;
    localparam int DEFAULT_REPEAT_DELAY  = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD = 5000000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    typedef struct packed {
        logic rise;
        logic fall;
        logic press;
    } pulse_t;

    // An active-low input idles high, an active-high input idles low.
    function automatic logic idle_level(input bit active_low);
        return active_low;
    endfunction

    function automatic int clog2_min1(input int n);
        int w;
        int v;
        w = 0;
        v = (n > 1) ? n - 1 : 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// rtl/debounce_bank_if.sv - pin-side inputs and conditioned outputs of the debounce bank
interface debounce_bank_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] Sig;
    logic [NUM_CH-1:0] Desig;
    logic [NUM_CH-1:0] Rise;
    logic [NUM_CH-1:0] Fall;
    logic [NUM_CH-1:0] Press;
    logic              AnyEvent;

    modport master (output Sig, input Desig, Rise, Fall, Press, AnyEvent);
    modport slave  (input Sig, output Desig, Rise, Fall, Press, AnyEvent);
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: synchroniser, stability counter, edge pulses, hold-to-repeat FSM
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CLOCKS = DEFAULT_STABLE_CLOCKS,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   sig_i,
    output logic   desig_o,
    output pulse_t pulse_o
);

    localparam logic IDLE_LVL = idle_level(ACTIVE_LOW);
    localparam int   CNT_W    = clog2_min1(STABLE_CLOCKS);
    localparam int   REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   REP_W    = clog2_min1(REP_MAX);
    localparam bit   REP_ON   = REPEAT_EN && (REPEAT_DELAY != 0);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CLOCKS - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   desig_q, desig_d;
    pulse_t                 pulse_q, pulse_d;
    logic [1:0]             state_q, state_d;
    logic [REP_W-1:0]       rep_q, rep_d;
    logic                   sync_out;
    logic                   settle;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        desig_d = desig_q;
        cnt_d   = cnt_q;
        pulse_d = '0;
        state_d = state_q;
        rep_d   = rep_q;
        settle  = 1'b0;

        // Any agreeing sample restarts the stability window.
        if (sync_out == desig_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            desig_d = sync_out;
            cnt_d   = '0;
            settle  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        pulse_d.rise = settle & desig_d;
        pulse_d.fall = settle & ~desig_d;

        if (settle && (desig_d == IDLE_LVL)) begin
            state_d = ST_IDLE;
        end else if (settle) begin
            state_d       = ST_DELAY;
            rep_d         = '0;
            pulse_d.press = 1'b1;
        end else begin
            case (state_q)
                ST_DELAY: begin
                    // Non-repeating channels park here until release.
                    if (REP_ON) begin
                        if (rep_q == DELAY_LAST) begin
                            pulse_d.press = 1'b1;
                            rep_d         = '0;
                            state_d       = ST_REPEAT;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (rep_q == PERIOD_LAST) begin
                        pulse_d.press = 1'b1;
                        rep_d         = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= {SYNC_STAGES{IDLE_LVL}};
            cnt_q   <= '0;
            desig_q <= IDLE_LVL;
            pulse_q <= '0;
            state_q <= ST_IDLE;
            rep_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            desig_q <= desig_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
            rep_q   <= rep_d;
        end
    end

    assign desig_o = desig_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - bank of independent debounce channels with a registered any-event flag
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int              NUM_CH        = 4,
    parameter int              SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int              STABLE_CLOCKS = DEFAULT_STABLE_CLOCKS,
    parameter bit              ACTIVE_LOW    = 1'b1,
    parameter logic [NUM_CH-1:0] REPEAT_MASK = '0,
    parameter int              REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int              REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic              Clock,
    input  logic              Reset,
    debounce_bank_if.slave    bus
);

    logic [NUM_CH-1:0] desig_w;
    logic [NUM_CH-1:0] rise_w;
    logic [NUM_CH-1:0] fall_w;
    logic [NUM_CH-1:0] press_w;
    pulse_t            pulse_w [NUM_CH];
    logic              any_q, any_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CLOCKS(STABLE_CLOCKS),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_EN    (REPEAT_MASK[i]),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk_i  (Clock),
            .rst_i  (Reset),
            .sig_i  (bus.Sig[i]),
            .desig_o(desig_w[i]),
            .pulse_o(pulse_w[i])
        );
        assign rise_w[i]  = pulse_w[i].rise;
        assign fall_w[i]  = pulse_w[i].fall;
        assign press_w[i] = pulse_w[i].press;
    end

    assign any_d = |(rise_w | fall_w | press_w);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign bus.Desig    = desig_w;
    assign bus.Rise     = rise_w;
    assign bus.Fall     = fall_w;
    assign bus.Press    = press_w;
    assign bus.AnyEvent = any_q;

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel input conditioner for switches and push buttons. Each channel synchronises a raw asynchronous input, debounces it with a programmable stability window, and emits one-cycle rise, fall and press pulses, with optional hold-to-repeat on selected channels. It sits between the board pins and the UI/control logic, replacing per-pin synchroniser, debounce and edge-detect chains.

## Interface
- `NUM_CH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `STABLE_CLOCKS`, 1500000: consecutive cycles a new level must persist before `Desig` follows it (≥1).
- `ACTIVE_LOW`, 1: 1 means a pressed input reads 0 and the idle level is 1; 0 means the inverse.
- `REPEAT_MASK`, {NUM_CH{1'b0}}: per-channel auto-repeat enable.
- `REPEAT_DELAY`, 25000000: cycles from press to first repeat; 0 disables repeat on all channels.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeats (≥1).
- `Clock` in 1: system clock; the only clock.
- `Reset` in 1: synchronous, active-high reset.
- `Sig` in NUM_CH: raw asynchronous inputs.
- `Desig` out NUM_CH: debounced levels. Reset value is the idle level on every bit.
- `Rise` out NUM_CH: one-cycle pulse when `Desig` goes 0→1. Reset value 0.
- `Fall` out NUM_CH: one-cycle pulse when `Desig` goes 1→0. Reset value 0.
- `Press` out NUM_CH: one-cycle pulse on entry to the active level, plus repeat pulses. Reset value 0.
- `AnyEvent` out 1: registered OR of all `Rise|Fall|Press` bits, one cycle later. Reset value 0.

## Operation
- Synchroniser: `SYNC_STAGES` flops per channel. On reset, all stages load the idle level so that no edge appears after reset is released.
- Debounce counter (`CNT_W = clog2(STABLE_CLOCKS)` bits, minimum 1):
  - When the synchroniser output equals `Desig`: counter ← 0.
  - When they differ and counter == STABLE_CLOCKS-1: `Desig` ← synchroniser output, counter ← 0.
  - Otherwise: counter increments.
  - A single disagreeing-then-agreeing sample restarts the window. Glitches shorter than STABLE_CLOCKS never reach `Desig`.
- Pulses are registered in the same edge as the `Desig` update, so they are coincident with the first cycle of the new level. `Rise` and `Fall` are mutually exclusive per channel.
- Repeat FSM per channel, with states IDLE, DELAY and REPEAT:
  - IDLE → DELAY on the edge `Desig` becomes active. `Press`=1 on that edge and rep_cnt ← 0.
  - In DELAY, rep_cnt increments. At REPEAT_DELAY-1: `Press`=1, rep_cnt ← 0, go to REPEAT.
  - In REPEAT, a pulse fires every REPEAT_PERIOD cycles.
  - Any state → IDLE on the edge `Desig` becomes inactive. No `Press` on release.
  - Channels without the mask bit, or with REPEAT_DELAY=0, stay in IDLE/DELAY and never repeat.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Reset mid-operation: all counters, FSMs and outputs return to reset values on that edge. A held input after reset is re-debounced from scratch and produces a fresh `Press`.

## Timing
- Latency: with the first edge that samples a new stable `Sig` level numbered 1, `Desig`, `Rise`/`Fall` and `Press` change on edge SYNC_STAGES+STABLE_CLOCKS.
- `Press` repeats land on edges p+REPEAT_DELAY, then p+REPEAT_DELAY+n·REPEAT_PERIOD, where p is the press edge.
- `AnyEvent` lags the pulses by exactly 1 cycle.
- All outputs are registered. There is no combinational path from `Sig` to any output.

## Structure
- Package/header `debounce_pkg`: default timing constants, idle-level helper, clog2 width function.
- Sub-module `debounce_channel`, one instance per channel. It holds the synchroniser, debounce counter, edge pulses and repeat FSM. Instantiate it with generate over `NUM_CH`, passing `REPEAT_MASK[i]`.
- Top level: generate loop plus the `AnyEvent` OR register.

## Test plan
All scenarios use NUM_CH=4, SYNC_STAGES=2, STABLE_CLOCKS=4, ACTIVE_LOW=1, REPEAT_MASK=4'b0010, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset, `Sig`=4'hF held → `Desig`=4'hF and `Rise`/`Fall`/`Press`/`AnyEvent`=0 for 20 cycles.
- Ch0: `Sig[0]` 1→0 and held → `Desig[0]`=0, `Fall[0]`=1 and `Press[0]`=1 on edge 6 only; `AnyEvent` high on edge 7.
- Ch0: 0-glitches of 1, 2 and 3 cycles separated by 1-cycle highs → `Desig[0]` stays 1 and no pulses occur.
- Ch1: held low for 30 cycles after debounce → `Press[1]` at p, p+10, p+13, p+16, ...; release → `Rise[1]`, no further `Press`. Ch0 held identically → a single `Press`.
- Ch2 and ch3 released on the same cycle → `Rise[2]` and `Rise[3]` on the same edge.
- Reset asserted during ch1 REPEAT with input still low → all outputs idle next edge; after release, `Press[1]` again on edge 6.
